mult32x32_fsm: RTL and testbench

Control unit for the sequential 32x32 multiplier. It is the counterpart of `mult32x32_arith`: it accepts a start request, then drives `clr_prod`, `upd_prod`, `a_sel`, `b_sel` and `shift_sel` to accumulate eight 8x16 partial products into the 64-bit product register. It also reports `busy` to the requester. It sits beside `mult32x32_arith` inside the `mult32x32` integration top.

---
 rtl/mult32x32_pkg.sv | 15 +
 rtl/mult32x32_fsm.sv | 73 +++++++
 tb/tb_mult32x32_fsm.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mult32x32_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier control.
package mult32x32_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NUM_STEPS   = 8;
  localparam int STEP_W      = $clog2(NUM_STEPS);
  localparam int A_SEL_W     = 2;
  localparam int SHIFT_SEL_W = 3;
  localparam int SHIFT_UNIT  = 8;

endpackage

// File: rtl/mult32x32_fsm.sv
// Sequencer for the 32x32 multiplier: clears the product, then walks eight
// 8x16 partial products (four bytes of a per halfword of b) into the accumulator.
//
// state | meaning
// IDLE  | waiting for start; clr_prod follows start combinationally
// RUN   | accumulating partial product number `step` (0..7)
module mult32x32_fsm
  import mult32x32_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic [A_SEL_W-1:0]     a_sel,
  output logic                   b_sel,
  output logic [SHIFT_SEL_W-1:0] shift_sel,
  output logic                   upd_prod,
  output logic                   clr_prod
);

  state_t            state;
  logic [STEP_W-1:0] step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            step  <= '0;
          end
        end
        RUN: begin
          if (step == STEP_W'(NUM_STEPS - 1)) begin
            state <= IDLE;
            step  <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          step  <= '0;
        end
      endcase
    end
  end

  // Outputs decode from state/step so an async reset silences them immediately.
  always_comb begin
    busy      = 1'b0;
    upd_prod  = 1'b0;
    clr_prod  = 1'b0;
    a_sel     = '0;
    b_sel     = 1'b0;
    shift_sel = '0;
    case (state)
      IDLE: clr_prod = start;
      RUN: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        a_sel     = step[1:0];
        b_sel     = step[2];
        shift_sel = {1'b0, step[1:0]} + {1'b0, step[2], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult32x32_fsm.sv
// Directed bench for mult32x32_fsm with a behavioural product accumulator beside it.
module tb_mult32x32_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic [1:0]  a_sel;
  logic        b_sel;
  logic [2:0]  shift_sel;
  logic        upd_prod;
  logic        clr_prod;

  logic [31:0] a, b;
  logic [63:0] prod;

  int passed = 0;
  int total  = 0;

  // Expected shift_sel per step, computed by hand from byte/halfword weights.
  int exp_shift [8] = '{0, 1, 2, 3, 2, 3, 4, 5};

  mult32x32_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .shift_sel (shift_sel),
    .upd_prod  (upd_prod),
    .clr_prod  (clr_prod)
  );

  always #5 clk = ~clk;

  // Stand-in for the arith datapath: 8x16 partial product shifted by 8*shift_sel.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      prod <= 64'd0;
    end else if (clr_prod) begin
      prod <= 64'd0;
    end else if (upd_prod) begin
      prod <= prod + ((64'((a >> (8 * a_sel)) & 32'hFF) *
                       64'(b_sel ? b[31:16] : b[15:0])) << (8 * shift_sel));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // {busy, upd_prod, clr_prod, a_sel, b_sel, shift_sel}
  function automatic logic [8:0] ctl_exp(input logic bz, input logic up, input logic cl,
                                         input int as, input int bs, input int ss);
    return {bz, up, cl, 2'(as), 1'(bs), 3'(ss)};
  endfunction

  task automatic check_ctl(input string tag, input logic [8:0] exp);
    check(tag, {55'd0, busy, upd_prod, clr_prod, a_sel, b_sel, shift_sel}, {55'd0, exp});
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Runs cycles 1..8 of an operation (driver sits just after the edge opening cycle 1).
  task automatic check_run(input string tag);
    for (int k = 0; k < 8; k++) begin
      #1;
      check_ctl($sformatf("%s_step%0d", tag, k), ctl_exp(1, 1, 0, k % 4, k / 4, exp_shift[k]));
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;

    // Reset held for 4 cycles
    repeat (4) @(posedge clk);
    #2;
    check_ctl("in_reset", ctl_exp(0, 0, 0, 0, 0, 0));
    #(-1+1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_ctl($sformatf("idle%0d", i), ctl_exp(0, 0, 0, 0, 0, 0));
      next_cycle();
    end

    // Single start pulse, a=FF, b=FFFF0000
    a     = 32'h000000FF;
    b     = 32'hFFFF0000;
    start = 1'b1;
    #1;
    check_ctl("pulse_c0", ctl_exp(0, 0, 1, 0, 0, 0));
    next_cycle();
    start = 1'b0;
    check_run("pulse");
    #1;
    check_ctl("pulse_c9", ctl_exp(0, 0, 0, 0, 0, 0));
    check("prod_ff", prod, 64'h000000FEFF010000);
    next_cycle();

    // All-ones operands
    a     = 32'hFFFFFFFF;
    b     = 32'hFFFFFFFF;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (8) next_cycle();
    #1;
    check("busy_ones_c9", {63'd0, busy}, 64'd0);
    check("prod_ones", prod, 64'hFFFFFFFE00000001);
    next_cycle();

    // Start held high throughout: one op, then restart in cycle 9
    start = 1'b1;
    #1;
    check_ctl("hold_c0", ctl_exp(0, 0, 1, 0, 0, 0));
    next_cycle();
    check_run("hold");
    #1;
    check_ctl("hold_c9", ctl_exp(0, 0, 1, 0, 0, 0));
    check("prod_hold", prod, 64'hFFFFFFFE00000001);
    next_cycle();
    start = 1'b0;

    // Second (restarted) op now at step 0; advance to step 3 then reset mid-cycle
    repeat (3) next_cycle();
    #1;
    check_ctl("pre_rst_step3", ctl_exp(1, 1, 0, 3, 0, 3));
    #2;
    reset = 1'b1;
    #1;
    check_ctl("async_rst", ctl_exp(0, 0, 0, 0, 0, 0));
    check("prod_rst", prod, 64'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Clean operation after reset
    a     = 32'd12345;
    b     = 32'd6789;
    start = 1'b1;
    #1;
    check_ctl("post_rst_c0", ctl_exp(0, 0, 1, 0, 0, 0));
    next_cycle();
    start = 1'b0;
    check_run("post_rst");
    #1;
    check_ctl("post_rst_c9", ctl_exp(0, 0, 0, 0, 0, 0));
    check("prod_dec", prod, 64'd83810205);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
